pwm_multi: RTL and testbench



---
 rtl/pwm_pkg.sv | 14 +
 rtl/pwm_chan.sv | 34 +++
 rtl/pwm_multi.sv | 88 ++++++++
 tb/tb_pwm_multi.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_pkg.sv
// Shared types and helpers for the multi-channel PWM generator.
package pwm_pkg;

  typedef enum logic {
    PWM_EDGE   = 1'b0,
    PWM_CENTER = 1'b1
  } pwm_mode_t;

  // Width of a channel index; a single channel still gets a 1-bit select.
  function automatic int ch_width(input int channels);
    return (channels > 1) ? $clog2(channels) : 1;
  endfunction

endpackage

// File: rtl/pwm_chan.sv
// One PWM channel: double-buffered duty (pending/active) and a registered
// compare against the shared period counter.
module pwm_chan #(
  parameter int WIDTH = 11
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic             wr,
  input  logic [WIDTH-1:0] wr_duty,
  input  logic [WIDTH-1:0] cnt,
  output logic             pwm
);

  logic [WIDTH-1:0] pending;
  logic [WIDTH-1:0] active;

  // NOTE: duty registers are plain flops, not a memory, so they are reset
  // along with everything else; a reset must never replay a stale duty.
  always_ff @(posedge clk) begin
    if (rst) begin
      pending <= '0;
      active  <= '0;
      pwm     <= 1'b0;
    end else begin
      if (wr) pending <= wr_duty;
      // A same-cycle write lands in pending; active takes the older value.
      if (load) active <= pending;
      pwm <= en && (cnt < active);
    end
  end

endmodule

// File: rtl/pwm_multi.sv
// Multi-channel PWM: one shared edge/center-aligned period counter feeding
// CHANNELS compare outputs whose duties swap in only at period boundaries.
module pwm_multi
  import pwm_pkg::*;
#(
  parameter  int WIDTH    = 11,
  parameter  int CHANNELS = 4,
  localparam int CH_W     = ch_width(CHANNELS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                mode_in,
  input  logic                wr_en,
  input  logic [CH_W-1:0]     wr_ch,
  input  logic [WIDTH-1:0]    wr_duty,
  output logic [CHANNELS-1:0] pwm_out,
  output logic                period_start
);

  localparam logic [WIDTH-1:0] MAX = '1;
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  logic [WIDTH-1:0]    cnt;
  logic                dir_down;
  pwm_mode_t           mode;
  logic                boundary;
  logic                load;
  logic                wr_valid;
  logic [CHANNELS-1:0] wr_sel;

  // Boundary = last cycle of a period, i.e. the next count is zero.
  // NOTE: every combinational output gets a default first so no latch forms.
  always_comb begin
    boundary = 1'b0;
    if (en) begin
      if (mode == PWM_EDGE) boundary = (cnt == MAX);
      else                  boundary = dir_down && (cnt == ONE);
    end
  end

  // While idle the active duties follow pending so a restart uses them at once.
  assign load     = boundary || !en;
  assign wr_valid = wr_en && (int'(wr_ch) < CHANNELS);

  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt          <= '0;
      dir_down     <= 1'b0;
      mode         <= PWM_EDGE;
      period_start <= 1'b0;
    end else begin
      period_start <= en && (cnt == '0);
      if (!en || boundary) begin
        cnt      <= '0;
        dir_down <= 1'b0;
        mode     <= pwm_mode_t'(mode_in);
      end else if (mode == PWM_CENTER && !dir_down && cnt == MAX) begin
        dir_down <= 1'b1;
        cnt      <= MAX - ONE;
      end else if (dir_down) begin
        cnt <= cnt - ONE;
      end else begin
        cnt <= cnt + ONE;
      end
    end
  end

  for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
    assign wr_sel[i] = wr_valid && (int'(wr_ch) == i);

    pwm_chan #(
      .WIDTH (WIDTH)
    ) u_chan (
      .clk     (clk),
      .rst     (rst),
      .en      (en),
      .load    (load),
      .wr      (wr_sel[i]),
      .wr_duty (wr_duty),
      .cnt     (cnt),
      .pwm     (pwm_out[i])
    );
  end

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi (WIDTH=4, CHANNELS=4) using a
// period-phase reference model plus directed and randomized stimulus.
module tb_pwm_multi;

  localparam int WIDTH = 4;
  localparam int CHN   = 4;
  localparam int MAXV  = (1 << WIDTH) - 1;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           en = 1'b0;
  logic           mode_in = 1'b0;
  logic           wr_en = 1'b0;
  logic [1:0]     wr_ch = '0;
  logic [3:0]     wr_duty = '0;
  logic [CHN-1:0] pwm_out;
  logic           period_start;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: position within the period and per-channel duties.
  int       m_pend[CHN];
  int       m_act[CHN];
  int       m_p = 0;
  bit       m_center = 1'b0;
  logic [CHN-1:0] exp_pwm = '0;
  logic     exp_ps = 1'b0;

  pwm_multi #(
    .WIDTH    (WIDTH),
    .CHANNELS (CHN)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .en           (en),
    .mode_in      (mode_in),
    .wr_en        (wr_en),
    .wr_ch        (wr_ch),
    .wr_duty      (wr_duty),
    .pwm_out      (pwm_out),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  function automatic int period_len(input bit center);
    return center ? 2 * MAXV : MAXV + 1;
  endfunction

  // Counter value at phase p: ramp up, then (center) ramp back down.
  function automatic int cnt_at(input int p, input bit center);
    if (!center || p <= MAXV) return p;
    return 2 * MAXV - p;
  endfunction

  task automatic model_step();
    if (rst) begin
      for (int i = 0; i < CHN; i++) begin
        m_pend[i] = 0;
        m_act[i]  = 0;
      end
      m_p = 0;
      m_center = 1'b0;
      exp_pwm = '0;
      exp_ps = 1'b0;
    end else begin
      for (int i = 0; i < CHN; i++)
        exp_pwm[i] = en && (cnt_at(m_p, m_center) < m_act[i]);
      exp_ps = en && (m_p == 0);
      if (!en || m_p == period_len(m_center) - 1) begin
        for (int i = 0; i < CHN; i++) m_act[i] = m_pend[i];
        m_center = mode_in;
        m_p = 0;
      end else begin
        m_p = m_p + 1;
      end
      if (wr_en && int'(wr_ch) < CHN) m_pend[wr_ch] = int'(wr_duty);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    checks++;
    assert (pwm_out === exp_pwm)
      else begin
        errors++;
        $error("FAIL pwm_out cyc=%0d observed=%b expected=%b", cyc, pwm_out, exp_pwm);
      end
    checks++;
    assert (period_start === exp_ps)
      else begin
        errors++;
        $error("FAIL period_start cyc=%0d observed=%b expected=%b", cyc, period_start, exp_ps);
      end
  endtask

  task automatic write(input int ch, input int d);
    wr_en = 1'b1;
    wr_ch = 2'(ch);
    wr_duty = 4'(d);
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_ps();
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (period_start !== 1'b1 && n < 64);
    checks++;
    assert (period_start === 1'b1)
      else begin
        errors++;
        $error("FAIL wait_ps timeout observed=%b expected=1", period_start);
      end
  endtask

  // Starting on an observed period_start, count high cycles of one channel
  // over len cycles, optionally writing ch0 at offset wr_at, then require the
  // next period_start exactly len cycles later.
  task automatic measure(input int len, input int ch, input int wr_at,
                         input int wd, input int exp_hi, input string tag);
    int hi;
    hi = int'(pwm_out[ch]);
    for (int k = 1; k < len; k++) begin
      if (k == wr_at) begin
        wr_en = 1'b1;
        wr_ch = 2'd0;
        wr_duty = 4'(wd);
      end
      step();
      wr_en = 1'b0;
      hi += int'(pwm_out[ch]);
    end
    step();
    checks++;
    assert (period_start === 1'b1)
      else begin
        errors++;
        $error("FAIL %s period_len observed_ps=%b expected=1 after %0d cycles", tag, period_start, len);
      end
    checks++;
    assert (hi == exp_hi)
      else begin
        errors++;
        $error("FAIL %s high_count observed=%0d expected=%0d", tag, hi, exp_hi);
      end
  endtask

  initial begin
    for (int i = 0; i < CHN; i++) begin
      m_pend[i] = 0;
      m_act[i]  = 0;
    end

    // Reset state
    rst = 1'b1;
    step();
    step();
    checks++;
    assert (pwm_out === '0 && period_start === 1'b0)
      else begin
        errors++;
        $error("FAIL reset observed=%b/%b expected=0000/0", pwm_out, period_start);
      end

    // Duties written while idle, then edge-aligned run
    rst = 1'b0;
    write(0, 5);
    write(1, 0);
    write(2, 15);
    step();
    en = 1'b1;
    mode_in = 1'b0;
    wait_ps();
    measure(16, 0, -1, 0, 5,  "edge_d5");
    measure(16, 1, -1, 0, 0,  "edge_d0");
    measure(16, 2, -1, 0, 15, "edge_d15");

    // Center-aligned
    write(0, 4);
    mode_in = 1'b1;
    wait_ps();
    measure(30, 0, -1, 0, 7,  "center_d4");
    measure(30, 2, -1, 0, 29, "center_d15");

    // Mid-period write, then write on the boundary cycle
    mode_in = 1'b0;
    wait_ps();
    measure(16, 0, 6,  8, 4, "wr_mid_old");
    measure(16, 0, 15, 3, 8, "wr_mid_new");
    measure(16, 0, -1, 0, 8, "wr_bnd_wait");
    measure(16, 0, -1, 0, 3, "wr_bnd_apply");

    // Mode switch mid-period applies at the next boundary
    mode_in = 1'b1;
    measure(16, 0, -1, 0, 3, "sw_old_edge");
    measure(30, 0, -1, 0, 5, "sw_new_center");

    // Reset mid-period with every output high
    mode_in = 1'b0;
    for (int i = 0; i < CHN; i++) write(i, 12);
    wait_ps();
    wait_ps();
    for (int i = 0; i < 8; i++) step();
    checks++;
    assert (pwm_out === 4'hF)
      else begin
        errors++;
        $error("FAIL pre_rst observed=%b expected=1111", pwm_out);
      end
    rst = 1'b1;
    step();
    checks++;
    assert (pwm_out === 4'h0 && period_start === 1'b0)
      else begin
        errors++;
        $error("FAIL mid_rst observed=%b/%b expected=0000/0", pwm_out, period_start);
      end
    rst = 1'b0;
    wait_ps();
    measure(16, 3, -1, 0, 0, "rst_cleared");

    // Randomized traffic checked cycle by cycle against the model
    for (int n = 0; n < 3000; n++) begin
      rst = ($urandom_range(0, 499) == 0);
      if ($urandom_range(0, 99) == 0) en = ~en;
      if ($urandom_range(0, 39) == 0) mode_in = ~mode_in;
      wr_en = ($urandom_range(0, 3) == 0);
      wr_ch = 2'($urandom);
      wr_duty = 4'($urandom);
      step();
    end
    rst = 1'b0;
    wr_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
